fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 9, meaning instruction width: opcode in bits [8:4], operands in bits [3:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port go  input  1  start-execution pulse.
REQ-006 SHALL have port stall  input  1  hold the fetch stream.
REQ-007 SHALL have port branch_taken  input  1  resolved branch or jump from the execute stage.
REQ-008 SHALL have port branch_target  input  PC_W  next PC when branch_taken is asserted.
REQ-009 SHALL have port imem_addr  output  PC_W  instruction-memory address, driven combinationally from pc.
REQ-010 SHALL have port imem_data  input  INSTR_W  instruction-memory data, valid one cycle after its address is presented.
REQ-011 SHALL have port instruction_out  output  INSTR_W  instruction to the decoder's instruction_in.
REQ-012 SHALL have port instr_valid  output  1  instruction_out is a real instruction, not a bubble.
REQ-013 SHALL have port pc_out  output  PC_W  PC of the instruction on instruction_out.
REQ-014 SHALL have port done  output  1  HALT instruction has been issued.

Function
REQ-015 SHALL implement FSM states IDLE, PRIME, RUN and HALTED.
REQ-016 SHALL in IDLE, on go, set pc=0 and move to PRIME; PRIME SHALL present address 0, set pc=1 and move to RUN on the next cycle.
REQ-017 SHALL in RUN, with stall=0 and branch_taken=0, register imem_data into instruction_out with instr_valid=1, drive pc_out = pc-1, and set pc = pc+1.
REQ-018 SHALL make the PC wrap modulo 2^PC_W (255 -> 0) with no error flag.
REQ-019 SHALL, on stall=1 without branch_taken, hold pc, instruction_out, instr_valid and pc_out, and re-present the same imem_addr.
REQ-020 SHALL give branch_taken priority over stall: set pc = branch_target, and the next cycle drive instruction_out = NOP (9'b11011_0000) with instr_valid=0, flushing the in-flight word; fetch resumes from the target the cycle after.
REQ-021 SHALL, when a RUN-cycle fetch has opcode 5'b11010 (HALT), issue it with instr_valid=1, enter HALTED, freeze pc and fetch no further.
REQ-022 SHALL, if branch_taken coincides with an incoming HALT fetch, apply the branch, discard the HALT and stay in RUN.
REQ-023 SHALL in HALTED drive done=1, instr_valid=0 and instruction_out=NOP, and ignore branch_taken and stall.
REQ-024 SHALL on go in HALTED clear done and restart as from IDLE (pc=0, PRIME); SHALL ignore go in PRIME and RUN.
REQ-025 SHALL drive instruction_out=NOP and instr_valid=0 in IDLE and PRIME.

Reset
REQ-026 SHALL on rst_n=0, immediately and independent of clk, set state=IDLE, pc=0, instruction_out=NOP, instr_valid=0, pc_out=0, done=0.
REQ-027 SHALL abandon any fetch in flight when reset asserts mid-RUN and SHALL issue nothing until a new go.

Configuration
REQ-028 SHALL, with macro FETCH_CYCLE_COUNT_EN defined, add output cycle_count (16 bits) that counts RUN cycles including stalls, saturates at 16'hFFFF, clears on go and reset, and holds in HALTED.
REQ-029 SHALL, without FETCH_CYCLE_COUNT_EN, have no cycle_count port or counter logic, with all other behaviour identical.

Structure
REQ-030 SHALL take the opcode constants (HALT, the NOP/toBeDefined opcode), the NOP encoding, the FSM state enum and PC_W/INSTR_W defaults from shared package cpu_isa_pkg, which the decoder also uses.
REQ-031 SHALL place the PC register with its increment, load and hold logic in sub-module fetch_pc_counter; the FSM and output register stay in fetch_unit.

Verification
REQ-032 SHALL cover: reset, go, memory holds ADD at 0..3 -> instr_valid rises 2 cycles after go; pc_out reads 0,1,2,3 on consecutive cycles.
REQ-033 SHALL cover: stall held 3 cycles at pc_out=2 -> instruction_out and pc_out are unchanged for 3 cycles, then pc_out=3.
REQ-034 SHALL cover: branch_taken with target 8'h40 while pc_out=5 -> one cycle of NOP with instr_valid=0, then pc_out=8'h40; stall asserted at the same time is ignored.
REQ-035 SHALL cover: HALT at address 6 -> issued with instr_valid=1, then done=1, imem_addr frozen at 7, a later branch_taken is ignored, and go restarts at pc_out=0.
REQ-036 SHALL cover: branch_taken coinciding with the HALT fetch -> done stays 0 and fetch continues at the target.
REQ-037 SHALL cover: PC at 8'hFF with no branch -> next pc_out=0; rst_n pulsed mid-RUN -> outputs read NOP/0 at once, with or without clk.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA constants, fetch FSM encodings and width defaults shared by fetch and decode
package cpu_isa_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 9;

  localparam logic [4:0] OPC_HALT  = 5'b11010;
  localparam logic [4:0] OPC_NOP   = 5'b11011;
  localparam logic [8:0] NOP_INSTR = 9'b11011_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE   = 2'd0;
  localparam fetch_state_t ST_PRIME  = 2'd1;
  localparam fetch_state_t ST_RUN    = 2'd2;
  localparam fetch_state_t ST_HALTED = 2'd3;

  function automatic logic is_halt(input logic [4:0] opcode);
    return opcode == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// rtl/fetch_pc_counter.sv - program counter with load, increment and hold; wraps modulo 2^PC_W
module fetch_pc_counter
  import cpu_isa_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM and output register; FETCH_CYCLE_COUNT_EN adds a RUN-cycle counter
module fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic               done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]        cycle_count
`endif
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               done_q, done_d;
  logic               flush_q, flush_d;
  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_data_q, hold_data_d;

  logic               pc_load;
  logic [PC_W-1:0]    pc_load_val;
  logic               pc_inc;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] fetch_word;

  fetch_pc_counter #(.PC_W(PC_W)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pc_load),
    .load_val_i(pc_load_val),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  // A stall lets the memory advance to the next address, so the in-flight word is parked here.
  assign fetch_word = hold_valid_q ? hold_data_q : imem_data;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    pc_out_d     = pc_out_q;
    done_d       = done_q;
    flush_d      = flush_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    pc_load      = 1'b0;
    pc_load_val  = '0;
    pc_inc       = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        instr_d = NOP_W;
        valid_d = 1'b0;
        done_d  = (state_q == ST_HALTED);
        if (go) begin
          done_d  = 1'b0;
          pc_load = 1'b1;
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        instr_d      = NOP_W;
        valid_d      = 1'b0;
        flush_d      = 1'b0;
        hold_valid_d = 1'b0;
        pc_inc       = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_load      = 1'b1;
          pc_load_val  = branch_target;
          instr_d      = NOP_W;
          valid_d      = 1'b0;
          flush_d      = 1'b1;
          hold_valid_d = 1'b0;
        end else if (stall) begin
          if (!flush_q && !hold_valid_q) begin
            hold_data_d  = imem_data;
            hold_valid_d = 1'b1;
          end
        end else if (flush_q) begin
          // Word returned for the pre-branch address is dropped while the target is fetched.
          instr_d = NOP_W;
          valid_d = 1'b0;
          flush_d = 1'b0;
          pc_inc  = 1'b1;
        end else begin
          instr_d      = fetch_word;
          valid_d      = 1'b1;
          pc_out_d     = pc - PC_W'(1);
          hold_valid_d = 1'b0;
          if (is_halt(fetch_word[INSTR_W-1 -: 5])) begin
            state_d = ST_HALTED;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= NOP_W;
      valid_q      <= 1'b0;
      pc_out_q     <= '0;
      done_q       <= 1'b0;
      flush_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= NOP_W;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      pc_out_q     <= pc_out_d;
      done_q       <= done_d;
      flush_q      <= flush_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
    end else if (go && (state_q == ST_IDLE || state_q == ST_HALTED)) begin
      cycle_count_q <= '0;
    end else if (state_q == ST_RUN && cycle_count_q != 16'hFFFF) begin
      cycle_count_q <= cycle_count_q + 16'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

  assign imem_addr       = pc;
  assign instruction_out = instr_q;
  assign instr_valid     = valid_q;
  assign pc_out          = pc_out_q;
  assign done            = done_q;

endmodule
